wb_slave_mem: RTL
=================

// Module: wb_slave_mem
// PURPOSE
//  Pipelined Wishbone B4 responder backing the l1_top Wishbone master: word-addressed SRAM model, in-order
//  responses after a fixed latency, stall-based flow control. Used as the memory end of L1 benches and as
//  the on-chip RAM slave in system builds.
// PARAMETERS
//  MEM_WORDS   1024  number of 32-bit words; legal word index 0..MEM_WORDS-1
//  LATENCY     2     cycles from acceptance edge to response (1..8)
//  FIFO_DEPTH  4     outstanding requests before stall (power of two, >=2)
// PORTS
//  wb_clk_i    in   1   clock, all logic on rising edge
//  wb_rst_i    in   1   reset, asynchronous, active-high
//  wb_cyc_i    in   1   bus cycle active
//  wb_stb_i    in   1   request strobe
//  wb_we_i     in   1   1 = write, 0 = read
//  wb_adr_i    in   32  byte address; word index = adr[31:2]
//  wb_sel_i    in   4   byte enables (write lanes)
//  wb_dat_i    in   32  write data
//  wb_lock_i   in   1   ignored
//  wb_tga_i    in   1   ignored
//  wb_tgc_i    in   1   ignored
//  wb_dat_o    out  32  read data, valid with wb_ack_o on reads
//  wb_ack_o    out  1   normal termination, one per accepted request
//  wb_err_o    out  1   error termination (replaces ack)
//  wb_rty_o    out  1   tied 0
//  wb_stall_o  out  1   request not accepted this cycle
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): ack/err/rty=0, dat_o=0, stall=0, FIFO empty. Memory not cleared.
//  - Accept = cyc_i & stb_i & !stall_o at rising edge. stall_o = (count == FIFO_DEPTH), from registered count.
//  - Memory op executes at the acceptance edge: write updates only lanes with sel_i[b]=1;
//    read captures the word into the FIFO entry. Same-word read after write in back-to-back cycles returns new data.
//  - Error: adr[1:0]!=0 or word index >= MEM_WORDS -> no memory access, entry flagged err, dat_o=0.
//  - Each entry carries countdown loaded with LATENCY-1; all entries decrement per cycle, saturating at 0.
//  - Response: head entry with countdown 0 pops; registered ack_o (or err_o) high the following cycle, exactly
//    one cycle wide. Request accepted at edge E0 responds in the cycle after edge E(LATENCY-1), i.e. LATENCY
//    cycles after acceptance. At most one response per cycle; strict acceptance order.
//  - Throughput: one request/cycle sustained when FIFO_DEPTH >= LATENCY+1; otherwise stalls appear.
//  - Simultaneous push and pop in a cycle: count unchanged; full + pop same cycle still stalls (no bypass).
//  - cyc_i low: FIFO flushed same edge, countdowns discarded; ack_o/err_o forced 0 next cycle. Committed
//    writes remain. stb_i while cyc_i low ignored.
//  - Reset mid-transaction: FIFO cleared immediately, no response issued for pending entries.
//  - Pointer wrap: log2(FIFO_DEPTH)-bit rd/wr pointers wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  - wb_pkg: WB_DAT_W=32, WB_ADR_W=32, WB_SEL_W=4, typedef wb_resp_t {logic err; logic [31:0] dat;
//    logic [3:0] cnt}; shared with the L1 Wishbone master and bench agents.
//  - Sub-module wb_resp_fifo: FIFO of wb_resp_t with per-entry countdown, push/pop/flush, full/empty/head_ready.
//  - Top: accept decode, address check, memory array with byte-lane write, response output registers.
// TESTING
//  - LATENCY=2: write 0xDEADBEEF @0x10 sel=F, then read @0x10 -> ack 2 cycles after each accept, dat_o=0xDEADBEEF.
//  - Byte lanes: write 0x11223344 @0x20 sel=F, write 0xAABBCCDD sel=0101 -> read returns 0x11BB33DD.
//  - Back-to-back 8 reads @0x0..0x1C, FIFO_DEPTH=4, LATENCY=2 -> no stall, 8 acks in order on consecutive cycles.
//  - LATENCY=8, FIFO_DEPTH=4: 6 reads -> stall_o high after 4th accept, drops as 1st response pops; 6 acks in order.
//  - Errors: read @0x2 and read @(MEM_WORDS*4) -> err_o (no ack), dat_o=0; following valid read acks normally.
//  - Drop cyc_i with 3 outstanding -> no ack/err afterwards; new cycle read of earlier-written word returns written
//    data; assert wb_rst_i mid-stream -> outputs 0 asynchronously, stall_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Wishbone shared definitions: bus widths and the response record carried through the slave's response queue.
package wb_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_ADR_W = 32;
    localparam int WB_SEL_W = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
        logic [3:0]  cnt;
    } wb_resp_t;

    localparam int RESP_W = $bits(wb_resp_t);

    function automatic logic [3:0] cnt_dec(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

endpackage

// File: rtl/wb_resp_fifo.sv
// In-order response queue; every entry counts down each cycle and the head may leave once its count reaches 0.
module wb_resp_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [RESP_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [RESP_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_head_ready
);

    localparam int PW = $clog2(DEPTH);

    wb_resp_t      r_ent [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    wb_resp_t      w_head;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // A freshly pushed entry takes its full load value; all others age by one.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (r_wr_ptr == PW'(i))) begin
                    r_ent[i] <= i_push_data;
                end else begin
                    r_ent[i].cnt <= cnt_dec(r_ent[i].cnt);
                end
            end
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_head       = r_ent[r_rd_ptr];
    assign o_head       = w_head;
    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == (PW + 1)'(DEPTH));
    assign o_head_ready = !o_empty && (w_head.cnt == 4'd0);

endmodule

// File: rtl/wb_slave_mem.sv
// Pipelined Wishbone memory slave: requests execute on acceptance, responses return in order after a fixed latency.
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_lock_i,
    input  logic        wb_tga_i,
    input  logic        wb_tgc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        wb_stall_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);
    localparam logic [3:0]  LOAD_CNT  = 4'(LATENCY - 1);

    logic [31:0] r_mem [MEM_WORDS];
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic        w_full;
    logic        w_empty;
    logic        w_head_ready;
    logic        w_accept;
    logic        w_pop;
    logic        w_adr_err;
    logic [29:0] w_word_idx;
    logic [AW-1:0] w_mem_idx;
    logic [31:0] w_rd_word;
    wb_resp_t    w_push_data;
    wb_resp_t    w_head;
    logic        w_unused;

    assign w_accept   = wb_cyc_i && wb_stb_i && !w_full;
    assign w_word_idx = wb_adr_i[31:2];
    assign w_mem_idx  = w_word_idx[AW-1:0];
    assign w_adr_err  = (wb_adr_i[1:0] != 2'b00) || (w_word_idx >= MEM_LIMIT);
    assign w_rd_word  = r_mem[w_mem_idx];
    assign w_pop      = wb_cyc_i && w_head_ready;

    always_comb begin
        w_push_data     = '0;
        w_push_data.err = w_adr_err;
        w_push_data.cnt = LOAD_CNT;
        if (!w_adr_err && !wb_we_i) begin
            w_push_data.dat = w_rd_word;
        end
    end

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge wb_clk_i) begin
        if (w_accept && wb_we_i && !w_adr_err) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (wb_sel_i[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    wb_resp_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (wb_clk_i),
        .i_rst        (wb_rst_i),
        .i_push       (w_accept),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .i_flush      (!wb_cyc_i),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_ready (w_head_ready)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else if (!wb_cyc_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else if (w_head_ready) begin
            r_ack <= !w_head.err;
            r_err <= w_head.err;
            r_dat <= w_head.dat;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign wb_dat_o   = r_dat;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = w_full;

    assign w_unused = &{1'b0, wb_lock_i, wb_tga_i, wb_tgc_i, w_empty, w_head.cnt};

endmodule
